// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//  Brings up the core PLL from the free-running reference clock and gates the core reset.
//  It pulses the PLL reset and waits for lock, with a timeout and a bounded number of retries.
//  Lock must then stay high for a qualification window before the core reset is released.
//  A loss of lock while running re-asserts the core reset and restarts the whole sequence.
//
//  Ports
//    clk       in   reference clock (same net as the PLL refclk)
//    rst_n     in   asynchronous active-low reset
//    locked    in   PLL lock, asynchronous to clk
//    restart   in   one-clock pulse that forces a full re-sequence
//    pll_rst   out  active-high PLL reset
//    sys_rst   out  active-high core reset, low only in RUN
//    ready     out  high only in RUN
//    fail      out  high only in FAIL
//    lost_cnt  out  saturating count of lock losses seen in RUN
//    state     out  debug state: RESET=0 WAIT_LOCK=1 STABLE=2 RUN=3 FAIL=4
module pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 1000000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 4,
  parameter int unsigned CNT_W         = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [7:0] lost_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    StReset    = 3'd0,
    StWaitLock = 3'd1,
    StStable   = 3'd2,
    StRun      = 3'd3,
    StFail     = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] RstLast    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] StableLast = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RetryMax   = 4'(MAX_RETRIES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retries_q, retries_d;
  logic [7:0]       lost_q, lost_d;
  logic             locked_meta_q, locked_s_q;

  // Two-flop synchronizer; no filtering beyond the two-cycle latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_meta_q <= 1'b0;
      locked_s_q    <= 1'b0;
    end else begin
      locked_meta_q <= locked;
      locked_s_q    <= locked_meta_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    retries_d = retries_q;
    lost_d    = lost_q;
    if (restart) begin
      // Overrides every transition, including a lock loss seen in the same cycle.
      state_d   = StReset;
      cnt_d     = '0;
      retries_d = '0;
    end else begin
      unique case (state_q)
        StReset: begin
          if (cnt_q == RstLast) begin
            state_d = StWaitLock;
            cnt_d   = '0;
          end
        end
        StWaitLock: begin
          if (locked_s_q) begin
            state_d = StStable;
            cnt_d   = '0;
          end else if (cnt_q == TimeoutLast) begin
            retries_d = retries_q + 4'd1;
            state_d   = (retries_d == RetryMax) ? StFail : StReset;
            cnt_d     = '0;
          end
        end
        StStable: begin
          if (!locked_s_q) begin
            // A glitch during qualification is not charged as a retry.
            state_d = StWaitLock;
            cnt_d   = '0;
          end else if (cnt_q == StableLast) begin
            state_d   = StRun;
            cnt_d     = '0;
            retries_d = '0;
          end
        end
        StRun: begin
          cnt_d = cnt_q;
          if (!locked_s_q) begin
            state_d = StReset;
            cnt_d   = '0;
            lost_d  = (lost_q == 8'hff) ? lost_q : lost_q + 8'd1;
          end
        end
        StFail: begin
          cnt_d = cnt_q;
        end
        default: begin
          state_d = StReset;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StReset;
      cnt_q     <= '0;
      retries_q <= '0;
      lost_q    <= '0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retries_q <= retries_d;
      lost_q    <= lost_d;
      pll_rst   <= (state_d == StReset);
      sys_rst   <= (state_d != StRun);
      ready     <= (state_d == StRun);
      fail      <= (state_d == StFail);
    end
  end

  assign state    = state_q;
  assign lost_cnt = lost_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer
//  Directed sequence with randomized lock delays, glitch positions and RUN dwell times.
//  Expected cycle timing and the lost-lock count come from arithmetic on the sequencing
//  rules (synchronizer latency, phase lengths, saturation), not from a state-machine copy.
module tb_pll_lock_sequencer;

  localparam int R = 16;   // PLL reset pulse length
  localparam int T = 100;  // lock timeout
  localparam int S = 64;   // stability window
  localparam int M = 4;    // retries before FAIL

  localparam int ST_RESET = 0;
  localparam int ST_WAIT  = 1;
  localparam int ST_STAB  = 2;
  localparam int ST_RUN   = 3;
  localparam int ST_FAIL  = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       locked;
  logic       restart;
  logic       pll_rst, sys_rst, ready, fail;
  logic [7:0] lost_cnt;
  logic [2:0] state;

  int vectors    = 0;
  int miscompares = 0;
  int losses     = 0;

  pll_lock_sequencer #(
    .RST_CYCLES   (R),
    .LOCK_TIMEOUT (T),
    .STABLE_CYCLES(S),
    .MAX_RETRIES  (M),
    .CNT_W        (20)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .locked  (locked),
    .restart (restart),
    .pll_rst (pll_rst),
    .sys_rst (sys_rst),
    .ready   (ready),
    .fail    (fail),
    .lost_cnt(lost_cnt),
    .state   (state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input int st, input int p, input int s, input int r,
                      input int f);
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".pll_rst"}, 32'(pll_rst), 32'(p));
    check({tag, ".sys_rst"}, 32'(sys_rst), 32'(s));
    check({tag, ".ready"}, 32'(ready), 32'(r));
    check({tag, ".fail"}, 32'(fail), 32'(f));
  endtask

  function automatic int exp_lost();
    return (losses > 255) ? 255 : losses;
  endfunction

  // Counts how long pll_rst stays high from RESET entry; must be exactly R clocks.
  task automatic count_reset(input string tag);
    int n = 0;
    while (pll_rst && n < 200) begin
      tick();
      n++;
    end
    check({tag, ".pll_rst_len"}, 32'(n), 32'(R));
    outs({tag, ".wait"}, ST_WAIT, 0, 1, 0, 0);
  endtask

  // Lock arrives d clocks into WAIT_LOCK; STABLE follows after the 2-flop latency plus one.
  task automatic lock_to_stable(input string tag, input int d);
    repeat (d) tick();
    locked = 1'b1;
    tick();
    tick();
    check({tag, ".still_wait"}, 32'(state), ST_WAIT);
    tick();
    outs({tag, ".stable"}, ST_STAB, 0, 1, 0, 0);
  endtask

  task automatic stable_to_run(input string tag);
    repeat (S - 1) tick();
    check({tag, ".last_stable"}, 32'(state), ST_STAB);
    check({tag, ".sys_rst_held"}, 32'(sys_rst), 1);
    tick();
    outs({tag, ".run"}, ST_RUN, 0, 0, 1, 0);
  endtask

  task automatic drop_in_run(input string tag);
    locked = 1'b0;
    tick();
    tick();
    check({tag, ".run_2clk"}, 32'(state), ST_RUN);
    tick();
    losses++;
    outs({tag, ".reset_3clk"}, ST_RESET, 1, 1, 0, 0);
    check({tag, ".lost_cnt"}, 32'(lost_cnt), 32'(exp_lost()));
  endtask

  task automatic drop_with_restart(input string tag);
    locked = 1'b0;
    tick();
    tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    outs({tag, ".reset"}, ST_RESET, 1, 1, 0, 0);
    check({tag, ".lost_kept"}, 32'(lost_cnt), 32'(exp_lost()));
  endtask

  initial begin
    int d, g;
    rst_n   = 1'b1;
    locked  = 1'b0;
    restart = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    outs("por", ST_RESET, 1, 1, 0, 0);
    check("por.lost_cnt", 32'(lost_cnt), 0);
    tick();
    tick();
    rst_n = 1'b1;

    // Bring-up with a random lock delay.
    count_reset("t1");
    d = $urandom_range(5, 90);
    lock_to_stable("t1", d);
    stable_to_run("t1");

    // Lock loss in RUN, then a one-clock glitch during qualification.
    drop_in_run("t4");
    count_reset("t4");
    lock_to_stable("t2", $urandom_range(0, 40));
    g = $urandom_range(5, S - 10);
    repeat (g) tick();
    locked = 1'b0;
    tick();
    locked = 1'b1;
    tick();
    tick();
    outs("t2.glitch_wait", ST_WAIT, 0, 1, 0, 0);
    tick();
    check("t2.restable", 32'(state), ST_STAB);
    stable_to_run("t2");

    // Restart coinciding with a lock loss must not count it.
    drop_with_restart("t5a");
    count_reset("t5a");

    // No lock at all: M timeouts then FAIL.
    for (int k = 1; k <= M; k++) begin
      repeat (T - 1) tick();
      check("t3.wait_last", 32'(state), ST_WAIT);
      tick();
      if (k < M) begin
        outs("t3.retry", ST_RESET, 1, 1, 0, 0);
        count_reset("t3");
      end else begin
        outs("t3.fail", ST_FAIL, 0, 1, 0, 1);
      end
    end
    repeat ($urandom_range(5, 40)) tick();
    outs("t3.fail_hold", ST_FAIL, 0, 1, 0, 1);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    outs("t3.restart", ST_RESET, 1, 1, 0, 0);
    // Restart mid-RESET must restart the pulse count.
    repeat (5) tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    count_reset("t3.rerestart");

    // Repeated losses drive lost_cnt into saturation.
    for (int i = 0; i < 300; i++) begin
      lock_to_stable("t5", $urandom_range(0, 20));
      stable_to_run("t5");
      repeat ($urandom_range(0, 3)) tick();
      drop_in_run("t5");
      count_reset("t5");
    end
    check("t5.saturated", 32'(lost_cnt), 255);
    lock_to_stable("t5b", $urandom_range(0, 20));
    stable_to_run("t5b");
    drop_with_restart("t5b");
    count_reset("t5b");

    // Asynchronous reset in the middle of STABLE.
    lock_to_stable("t6", $urandom_range(0, 20));
    repeat ($urandom_range(1, S - 5)) tick();
    #2 rst_n = 1'b0;
    #1;
    outs("t6.async", ST_RESET, 1, 1, 0, 0);
    check("t6.lost_cnt", 32'(lost_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
